// File: rtl/soc_io_pkg.sv
// soc_io_pkg: shared register map, CNTL bit layout and UART state encoding for the IO page
package soc_io_pkg;
  localparam int IO_LEDS_bit = 0;
  localparam int IO_UART_DAT_bit = 1;
  localparam int IO_UART_CNTL_bit = 2;
  localparam int CNTL_TX_ACTIVE_bit = 8;
  localparam int CNTL_HOLD_FULL_bit = 9;
  localparam int CNTL_OVERRUN_bit = 10;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  function automatic logic [31:0] cntl_word(input logic overrun, input logic hold_full, input logic tx_active);
    cntl_word = '0;
    cntl_word[CNTL_OVERRUN_bit] = overrun;
    cntl_word[CNTL_HOLD_FULL_bit] = hold_full;
    cntl_word[CNTL_TX_ACTIVE_bit] = tx_active;
  endfunction
endpackage

// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter: 8N1 serialiser with baud down-counter; takes a byte whenever ready & load
module uart_tx_shifter
  import soc_io_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd,
  output logic       active
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);
  uart_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [9:0] shreg, shreg_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic tick;
  always_ff @(posedge clock)
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      shreg <= '1;
      bit_cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      shreg <= shreg_n;
      bit_cnt <= bit_cnt_n;
    end
  assign tick = cnt == '0;
  // ready in the last STOP cycle lets a queued byte follow with no idle gap
  assign ready = state == IDLE || (state == STOP && tick);
  assign txd = state == IDLE ? 1'b1 : shreg[0];
  assign active = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    shreg_n = shreg;
    bit_cnt_n = bit_cnt;
    if (load && ready) begin
      state_n = START;
      shreg_n = {1'b1, data, 1'b0};
      cnt_n = RELOAD;
    end else if (state != IDLE) begin
      cnt_n = tick ? RELOAD : cnt - 1'b1;
      if (tick) begin
        shreg_n = {1'b1, shreg[9:1]};
        bit_cnt_n = state == DATA ? bit_cnt + 1'b1 : '0;
        state_n = state == START ? DATA : state == DATA ? (bit_cnt == 3'd7 ? STOP : DATA) : IDLE;
      end
    end
  end
endmodule

// File: rtl/soc_io_uart.sv
// soc_io_uart: IO page decode, LED register, UART holding register and registered read mux
module soc_io_uart
  import soc_io_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ = 12_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int IO_BIT = 22
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] io_rdata,
  output logic [4:0]  leds,
  output logic        uart_txd,
  output logic        uart_busy
);
  localparam int DIV = CLOCK_FREQ_HZ / BAUD_RATE;
  logic is_io, store, load_io, sel_leds, sel_dat, sel_cntl;
  logic wr_leds, wr_dat, rd_cntl;
  logic hold_full, overrun, tx_active, tx_ready, take;
  logic [7:0] hold;
  logic [31:0] rd_val;
  logic unused_bits;
  assign is_io = mem_addr[IO_BIT];
  assign sel_leds = mem_addr[2+IO_LEDS_bit];
  assign sel_dat = mem_addr[2+IO_UART_DAT_bit];
  assign sel_cntl = mem_addr[2+IO_UART_CNTL_bit];
  assign store = is_io && |mem_wmask;
  assign load_io = is_io && mem_rstrb;
  assign wr_leds = store && sel_leds;
  assign wr_dat = store && sel_dat;
  assign rd_cntl = load_io && sel_cntl;
  assign take = hold_full && tx_ready;
  assign uart_busy = hold_full;
  assign unused_bits = ^{mem_addr, mem_wdata};
  assign rd_val = ({32{sel_leds}} & {27'b0, leds}) | ({32{sel_cntl}} & cntl_word(overrun, hold_full, tx_active));
  always_ff @(posedge clock)
    if (!resetn) begin
      leds <= '0;
      io_rdata <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (wr_leds) leds <= mem_wdata[4:0];
      io_rdata <= load_io ? rd_val : '0;
      if (wr_dat && (!hold_full || take)) begin
        hold <= mem_wdata[7:0];
        hold_full <= 1'b1;
      end else if (take) hold_full <= 1'b0;
      // a drop in the same cycle as a CNTL read keeps overrun set
      overrun <= (wr_dat && hold_full && !take) || (overrun && !rd_cntl);
    end
  uart_tx_shifter #(.DIV(DIV)) u_tx (
    .clock (clock),
    .resetn(resetn),
    .load  (take),
    .data  (hold),
    .ready (tx_ready),
    .txd   (uart_txd),
    .active(tx_active)
  );
endmodule

// File: tb/tb_soc_io_uart.sv
// tb_soc_io_uart: scoreboarded UART frames plus direct register checks, DIV=4
module tb_soc_io_uart;
  localparam int DIV = 4;
  localparam logic [31:0] IO = 32'h0040_0000;
  localparam logic [31:0] LEDS = IO | 32'h4, DAT = IO | 32'h8, CNTL = IO | 32'h10;
  logic clock = 0, resetn = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0;
  logic [3:0] mem_wmask = 0;
  logic mem_rstrb = 0;
  logic [31:0] io_rdata;
  logic [4:0] leds;
  logic uart_txd, uart_busy;
  int checks = 0, errors = 0, cycle = 0, frames = 0;
  logic [7:0] exp_q[$];
  int starts[$];
  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;
  soc_io_uart #(.CLOCK_FREQ_HZ(400), .BAUD_RATE(100), .IO_BIT(22)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb),
    .io_rdata (io_rdata),
    .leds     (leds),
    .uart_txd (uart_txd),
    .uart_busy(uart_busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    mem_addr = addr;
    mem_wdata = data;
    mem_wmask = 4'hf;
    cyc();
    mem_wmask = 0;
  endtask
  task automatic load(input logic [31:0] addr, output logic [31:0] data);
    mem_addr = addr;
    mem_rstrb = 1;
    cyc();
    mem_rstrb = 0;
    data = io_rdata;
  endtask
  task automatic send(input logic [7:0] b);
    exp_q.push_back(b);
    store(DAT, {24'b0, b});
  endtask
  task automatic wait_frames(input int n, input string tag);
    int k = 0;
    while (frames < n && k < 400) begin
      cyc();
      k++;
    end
    chk(tag, frames, n);
  endtask
  initial begin : monitor
    logic [9:0] f;
    logic [7:0] b;
    int bad;
    bit ab;
    forever begin
      cyc();
      if (resetn && !uart_txd) begin
        starts.push_back(cycle);
        chk("frame_queued", exp_q.size() != 0, 1);
        b = exp_q.size() != 0 ? exp_q.pop_front() : 8'hff;
        f = {1'b1, b, 1'b0};
        bad = 0;
        ab = 0;
        for (int k = 0; k < 10 * DIV; k++) begin
          if (k > 0) cyc();
          if (!resetn) begin
            ab = 1;
            break;
          end
          if (uart_txd !== f[k/DIV]) bad++;
        end
        if (!ab) begin
          chk("frame_bits", bad, 0);
          frames++;
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    logic [31:0] r;
    int n;
    repeat (3) cyc();
    chk("rst_rdata", io_rdata, 0);
    chk("rst_leds", leds, 0);
    chk("rst_txd", uart_txd, 1);
    chk("rst_busy", uart_busy, 0);
    resetn = 1;
    cyc();
    store(LEDS, 32'h15);
    chk("leds", leds, 5'h15);
    load(LEDS, r);
    chk("rd_leds", r, 32'h15);
    cyc();
    chk("rd_idle", io_rdata, 0);
    load(DAT, r);
    chk("rd_dat", r, 0);
    send(8'h41);
    n = 0;
    repeat (45) begin
      load(CNTL, r);
      if (r[8]) n++;
    end
    chk("active_cycles", n, 40);
    wait_frames(1, "frames_t2");
    send(8'h55);
    cyc();
    send(8'hAA);
    chk("busy_hold", uart_busy, 1);
    n = 0;
    while (starts.size() < 3 && n < 100) begin
      cyc();
      n++;
    end
    load(CNTL, r);
    chk("cntl_frame2", r, 32'h100);
    chk("b2b_gap", starts.size() >= 3 ? starts[2] - starts[1] : -1, 40);
    wait_frames(3, "frames_t3");
    send(8'h11);
    send(8'h22);
    store(DAT, 32'h33);
    chk("busy_ovr", uart_busy, 1);
    load(CNTL, r);
    chk("cntl_ovr", r, 32'h700);
    load(CNTL, r);
    chk("cntl_clr", r, 32'h300);
    wait_frames(5, "frames_t4");
    repeat (50) cyc();
    chk("no_third", frames, 5);
    chk("q_empty", exp_q.size(), 0);
    store(32'h4, 32'h0A);
    chk("nonio_leds", leds, 5'h15);
    store(32'h8, 32'h77);
    chk("nonio_busy", uart_busy, 0);
    load(32'h10, r);
    chk("nonio_rd_cntl", r, 0);
    load(32'h4, r);
    chk("nonio_rd_leds", r, 0);
    send(8'h5A);
    n = 0;
    while (uart_txd && n < 20) begin
      cyc();
      n++;
    end
    chk("t5_start", uart_txd, 0);
    repeat (4 + 12 + 1) cyc();
    resetn = 0;
    cyc();
    chk("midrst_txd", uart_txd, 1);
    chk("midrst_leds", leds, 0);
    chk("midrst_busy", uart_busy, 0);
    resetn = 1;
    load(CNTL, r);
    chk("midrst_cntl", r, 0);
    n = 0;
    repeat (60) begin
      cyc();
      if (!uart_txd) n++;
    end
    chk("no_residual", n, 0);
    chk("frames_total", frames, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
